// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered occupancy count, threshold flags and sticky error flags.
// It supports a registered-read mode and a first-word-fall-through read mode.
module fifo_sync_flags #(
    parameter int FIFO_DEPTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cs,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic                          clr_err,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic wr_req;
    logic rd_req;
    logic wr_accept;
    logic rd_accept;

    // The extra pointer MSB tells a full FIFO from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign almost_full  = (count_q >= CW'(AFULL_THRESH));
    assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));

    assign wr_req    = cs && wr_en;
    assign rd_req    = cs && rd_en;
    assign wr_accept = wr_req && !full;
    assign rd_accept = rd_req && !empty;

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // NOTE: sequential state uses non-blocking assignments, so every block samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_accept) rd_ptr <= rd_ptr + (AW+1)'(1);
            case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A set condition in the same cycle takes priority over clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_req && full)  overflow_q <= 1'b1;
            else if (clr_err)    overflow_q <= 1'b0;
            if (rd_req && empty) underflow_q <= 1'b1;
            else if (clr_err)    underflow_q <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; contents are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // NOTE: combinational block assigns a default first, so no latch is inferred.
            always_comb begin
                data_out = '0;
                if (!empty) data_out = mem[rd_ptr[AW-1:0]];
            end
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] rd_data_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)         rd_data_q <= '0;
                else if (rd_accept) rd_data_q <= mem[rd_ptr[AW-1:0]];
            end
            assign data_out = rd_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench: a registered-read and a FWFT instance share one stimulus stream
// and are compared against a queue-based reference model plus hand-derived vectors.
module tb_fifo_sync_flags;

    localparam int D  = 8;
    localparam int DW = 32;
    localparam int AF = 6;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs, wr_en, rd_en, clr_err;
    logic [DW-1:0] data_in;

    logic [DW-1:0] dout_r, dout_f;
    logic          empty_r, full_r, af_r, ae_r, ovf_r, unf_r;
    logic          empty_f, full_f, af_f, ae_f, ovf_f, unf_f;
    logic [3:0]    count_r, count_f;

    fifo_sync_flags #(.FIFO_DEPTH(D), .DATA_WIDTH(DW), .AFULL_THRESH(AF),
                      .AEMPTY_THRESH(AE), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
        .clr_err(clr_err), .data_in(data_in), .data_out(dout_r),
        .empty(empty_r), .full(full_r), .almost_full(af_r), .almost_empty(ae_r),
        .count(count_r), .overflow(ovf_r), .underflow(unf_r)
    );

    fifo_sync_flags #(.FIFO_DEPTH(D), .DATA_WIDTH(DW), .AFULL_THRESH(AF),
                      .AEMPTY_THRESH(AE), .FWFT(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
        .clr_err(clr_err), .data_in(data_in), .data_out(dout_f),
        .empty(empty_f), .full(full_f), .almost_full(af_f), .almost_empty(ae_f),
        .count(count_f), .overflow(ovf_f), .underflow(unf_f)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents as a queue, plus sticky flags and the registered read word.
    logic [DW-1:0] m_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_dout = '0;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            exp_count;
        logic          exp_empty;
        logic [DW-1:0] exp_dout;
        logic          exp_unf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = m_q.size();
        check("count",        32'(count_r), 32'(n));
        check("empty",        32'(empty_r), 32'(n == 0));
        check("full",         32'(full_r),  32'(n == D));
        check("almost_full",  32'(af_r),    32'(n >= AF));
        check("almost_empty", 32'(ae_r),    32'(n <= AE));
        check("overflow",     32'(ovf_r),   32'(m_ovf));
        check("underflow",    32'(unf_r),   32'(m_unf));
        check("data_out",     dout_r,       m_dout);
        check("f_count",      32'(count_f), 32'(n));
        check("f_empty",      32'(empty_f), 32'(n == 0));
        check("f_full",       32'(full_f),  32'(n == D));
        check("f_overflow",   32'(ovf_f),   32'(m_ovf));
        check("f_underflow",  32'(unf_f),   32'(m_unf));
        check("f_data_out",   dout_f,       (n != 0) ? m_q[0] : '0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare 1 time unit later.
    task automatic step(input logic c, input logic w, input logic r, input logic cl,
                        input logic [DW-1:0] d);
        logic is_full, is_empty;
        cs = c; wr_en = w; rd_en = r; clr_err = cl; data_in = d;
        @(posedge clk);
        is_full  = (m_q.size() == D);
        is_empty = (m_q.size() == 0);
        if (c && r && !is_empty) m_dout = m_q.pop_front();
        if (c && w && !is_full)  m_q.push_back(d);
        if (c && w && is_full)   m_ovf = 1'b1;
        else if (cl)             m_ovf = 1'b0;
        if (c && r && is_empty)  m_unf = 1'b1;
        else if (cl)             m_unf = 1'b0;
        #1;
        check_model();
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;

        vecs[0] = '{1'b1, 1'b0, 32'd1,   1, 1'b0, 32'd0,   1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'd10,  2, 1'b0, 32'd0,   1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'd100, 3, 1'b0, 32'd0,   1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd0,   2, 1'b0, 32'd1,   1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'd0,   1, 1'b0, 32'd10,  1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'd0,   0, 1'b1, 32'd100, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'd0,   0, 1'b1, 32'd100, 1'b1};

        #12;
        check("rst_count",        32'(count_r), 32'd0);
        check("rst_empty",        32'(empty_r), 32'd1);
        check("rst_full",         32'(full_r),  32'd0);
        check("rst_almost_empty", 32'(ae_r),    32'd1);
        check("rst_almost_full",  32'(af_r),    32'd0);
        check("rst_data_out",     dout_r,       32'd0);
        check("rst_f_data_out",   dout_f,       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Registered-read sequence: 3 writes, 4 reads.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vecs[i].wr, vecs[i].rd, 1'b0, vecs[i].din);
            check("vec_count",     32'(count_r), 32'(vecs[i].exp_count));
            check("vec_empty",     32'(empty_r), 32'(vecs[i].exp_empty));
            check("vec_data_out",  dout_r,       vecs[i].exp_dout);
            check("vec_underflow", 32'(unf_r),   32'(vecs[i].exp_unf));
        end

        // Fill past full, check overflow, drain in order, clear errors.
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("clr_underflow", 32'(unf_r), 32'd0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'd1 << i);
            if (i == 7) begin
                check("fill_full",  32'(full_r),  32'd1);
                check("fill_count", 32'(count_r), 32'd8);
            end
        end
        check("fill_overflow", 32'(ovf_r),   32'd1);
        check("fill_dropped",  32'(count_r), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, '0);
            check("drain_data", dout_r, 32'd1 << i);
        end
        check("drain_empty", 32'(empty_r), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("clr_overflow", 32'(ovf_r), 32'd0);

        // Read+write while full: write dropped, read taken, overflow set.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD);
        check("full_rw_count", 32'(count_r), 32'd7);
        check("full_rw_ovf",   32'(ovf_r),   32'd1);
        check("full_rw_data",  dout_r,       32'h100);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b1, '0);

        // Steady state at count=4 with simultaneous read+write; pointers wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h300 + 32'(i));
            check("rw_count", 32'(count_r), 32'd4);
            check("rw_data",  dout_r, (i < 4) ? 32'h200 + 32'(i) : 32'h300 + 32'(i - 4));
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0);

        // Threshold sweep 0..8..0.
        for (int i = 1; i <= 16; i++) begin
            int c;
            c = (i <= 8) ? i : 16 - i;
            step(1'b1, i <= 8, i > 8, 1'b0, 32'(i));
            check("sweep_af", 32'(af_r), 32'(c >= AF));
            check("sweep_ae", 32'(ae_r), 32'(c <= AE));
        end

        // FWFT: first word falls through, empty shows zero.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'hA5);
        check("fwft_data",  dout_f,       32'hA5);
        check("fwft_empty", 32'(empty_f), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("fwft_empty_after", 32'(empty_f), 32'd1);
        check("fwft_zero",        dout_f,       32'd0);

        // Asynchronous reset between edges at count=5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h400 + 32'(i));
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h405);
        check("pre_rst_count", 32'(count_r), 32'd5);
        cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("async_count", 32'(count_r), 32'd0);
        check("async_empty", 32'(empty_r), 32'd1);
        check("async_ae",    32'(ae_r),    32'd1);
        check("async_af",    32'(af_r),    32'd0);
        check("async_dout",  dout_r,       32'd0);
        check("async_f_cnt", 32'(count_f), 32'd0);
        model_reset();
        #2 rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h55);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("post_rst_data", dout_r, 32'h55);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 19) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of storage words; power of two, >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-2, occupancy at or above which almost_full asserts; range 1..FIFO_DEPTH.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 1, occupancy at or below which almost_empty asserts; range 0..FIFO_DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port cs  input  1  chip select; gates wr_en and rd_en.
REQ-009 SHALL have port wr_en  input  1  write request.
REQ-010 SHALL have port rd_en  input  1  read request (pop).
REQ-011 SHALL have port clr_err  input  1  synchronous clear of sticky error flags; not gated by cs.
REQ-012 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-013 SHALL have port data_out  output  DATA_WIDTH  read data.
REQ-014 SHALL have port empty  output  1  occupancy == 0.
REQ-015 SHALL have port full  output  1  occupancy == FIFO_DEPTH.
REQ-016 SHALL have port almost_full  output  1  occupancy >= AFULL_THRESH.
REQ-017 SHALL have port almost_empty  output  1  occupancy <= AEMPTY_THRESH.
REQ-018 SHALL have port count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
REQ-019 SHALL have port overflow  output  1  sticky: write attempted while full.
REQ-020 SHALL have port underflow  output  1  sticky: read attempted while empty.

Function
REQ-021 Write SHALL be accepted iff cs && wr_en && !full (full sampled before the edge); data_in stored at write pointer, pointer increments, wraps modulo FIFO_DEPTH.
REQ-022 Read SHALL be accepted iff cs && rd_en && !empty; read pointer increments, wraps modulo FIFO_DEPTH.
REQ-023 Pointers SHALL carry one extra MSB; empty = pointers equal; full = low bits equal, MSBs differ.
REQ-024 count SHALL be registered: +1 on write-only, -1 on read-only, unchanged on both or neither accepted.
REQ-025 Simultaneous accepted read and write (0 < count < FIFO_DEPTH) SHALL leave count and all flags unchanged.
REQ-026 Write while full SHALL be dropped (no pointer/memory change) even if a read is accepted the same cycle; read while empty SHALL be ignored even if a write is accepted the same cycle.
REQ-027 All flags (empty, full, almost_full, almost_empty) SHALL be combinational from registered count/pointers, valid the cycle after the accepting edge.
REQ-028 FWFT=0: data_out SHALL load the head word on the edge accepting a read (1-cycle latency) and hold otherwise.
REQ-029 FWFT=1: data_out SHALL equal the head word whenever !empty (valid the cycle after the first write into an empty FIFO) and SHALL be 0 whenever empty; a read advances to the next word on the following cycle.
REQ-030 overflow SHALL set on any edge with cs && wr_en && full; underflow SHALL set on any edge with cs && rd_en && empty.
REQ-031 clr_err SHALL clear both error flags on the edge; a set condition in the same cycle SHALL win.
REQ-032 cs=0 SHALL suppress all reads, writes and error-flag setting.

Reset
REQ-033 rst_n low SHALL immediately clear pointers, count, data_out, overflow, underflow; outputs become empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_THRESH>=1), count=0.
REQ-034 Reset mid-operation SHALL discard contents; memory array is not reset; first write after release goes to address 0.

Verification
REQ-035 FWFT=0, write 1,10,100 then 4 reads -> data_out 1,10,100 each one cycle after read; 4th read: data_out holds 100, underflow=1, empty=1.
REQ-036 Fill 9 writes (2**i, i=0..8) -> full=1 after 8th, count=8, 9th dropped, overflow=1; 8 reads return 1..128 in order, empty=1; clr_err -> overflow=0.
REQ-037 count=4, simultaneous read+write for 10 cycles -> count stays 4, pointers wrap, data order preserved.
REQ-038 AFULL_THRESH=6, AEMPTY_THRESH=1: step count 0..8..0 -> almost_full=1 iff count>=6, almost_empty=1 iff count<=1.
REQ-039 FWFT=1: write 0xA5 into empty -> next cycle data_out=0xA5, empty=0; read -> empty=1, data_out=0.
REQ-040 Assert rst_n low between edges at count=5 -> count=0, empty=1, flags cleared without waiting for clk.
